apb_spi_regif: RTL and testbench

APB3 slave front-end for the SPI master: it decodes APB transfers into the one-hot register strobes (WR0..WR3, DR0..DR3) and the write-data bus that the SPI master consumes. It returns the master's registered read data to the bus with correct PREADY wait states and flags illegal accesses with PSLVERR. It sits between the APB interconnect and the SPI master, on the same PCLK.

---
 rtl/apb_spi_pkg.sv | 32 +++
 rtl/apb_spi_addr_dec.sv | 42 ++++
 rtl/apb_spi_regif.sv | 140 ++++++++++++++
 tb/tb_apb_spi_regif.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB front-end of the SPI master: register map,
// strobe bit positions and the front-end FSM encoding.
package apb_spi_pkg;

  // Low three address bits; bit 2 selects the read-only half of the map.
  localparam logic [2:0] ADDR_CONFIG = 3'h0;
  localparam logic [2:0] ADDR_TX_WR  = 3'h1;
  localparam logic [2:0] ADDR_RX_WR  = 3'h2;
  localparam logic [2:0] ADDR_CMD_WR = 3'h3;
  localparam logic [2:0] ADDR_STATE  = 3'h4;
  localparam logic [2:0] ADDR_RX_RD  = 3'h5;
  localparam logic [2:0] ADDR_TX_RD  = 3'h6;
  localparam logic [2:0] ADDR_CMD_RD = 3'h7;

  // Positions in the 8-bit strobe vector {DR3..DR0, WR3..WR0}.
  localparam logic [2:0] STB_WR0 = 3'd0;
  localparam logic [2:0] STB_WR1 = 3'd1;
  localparam logic [2:0] STB_WR2 = 3'd2;
  localparam logic [2:0] STB_WR3 = 3'd3;
  localparam logic [2:0] STB_DR0 = 3'd4;
  localparam logic [2:0] STB_DR1 = 3'd5;
  localparam logic [2:0] STB_DR2 = 3'd6;
  localparam logic [2:0] STB_DR3 = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StRwait,
    StResp
  } apb_state_e;

endpackage

// File: rtl/apb_spi_addr_dec.sv
// Combinational decode of an APB address and direction into a one-hot
// register strobe vector plus an illegal-access flag.
module apb_spi_addr_dec
  import apb_spi_pkg::*;
#(
  parameter int unsigned AddrW = 4
) (
  input  logic [AddrW-1:0] addr,
  input  logic             write,
  output logic [7:0]       strb,
  output logic             err
);

  logic hi;
  logic bad_dir;

  if (AddrW > 3) begin : g_hi
    assign hi = |addr[AddrW-1:3];
  end else begin : g_no_hi
    assign hi = 1'b0;
  end

  always_comb begin
    strb    = '0;
    bad_dir = 1'b0;
    unique case (addr[2:0])
      ADDR_CONFIG: begin strb[STB_WR0] = write;  bad_dir = !write; end
      ADDR_TX_WR:  begin strb[STB_WR1] = write;  bad_dir = !write; end
      ADDR_RX_WR:  begin strb[STB_WR2] = write;  bad_dir = !write; end
      ADDR_CMD_WR: begin strb[STB_WR3] = write;  bad_dir = !write; end
      ADDR_STATE:  begin strb[STB_DR0] = !write; bad_dir = write;  end
      ADDR_RX_RD:  begin strb[STB_DR1] = !write; bad_dir = write;  end
      ADDR_TX_RD:  begin strb[STB_DR2] = !write; bad_dir = write;  end
      ADDR_CMD_RD: begin strb[STB_DR3] = !write; bad_dir = write;  end
    endcase
    err = hi | bad_dir;
    if (err) begin
      strb = '0;
    end
  end

endmodule

// File: rtl/apb_spi_regif.sv
// APB3 slave front-end for the SPI master: turns APB transfers into one-cycle
// register strobes and returns the master's read data with PREADY wait states.
module apb_spi_regif
  import apb_spi_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1  // legal range 1..7
) (
  input  logic              i_PCLK,
  input  logic              i_PRESET,
  input  logic              i_PSEL,
  input  logic              i_PENABLE,
  input  logic              i_PWRITE,
  input  logic [ADDR_W-1:0] i_PADDR,
  input  logic [7:0]        i_PWDATA,
  output logic [7:0]        o_PRDATA,
  output logic              o_PREADY,
  output logic              o_PSLVERR,
  output logic              o_WR0,
  output logic              o_WR1,
  output logic              o_WR2,
  output logic              o_WR3,
  output logic              o_DR0,
  output logic              o_DR1,
  output logic              o_DR2,
  output logic              o_DR3,
  output logic [7:0]        o_WDATA,
  input  logic [7:0]        i_RDATA
);

  apb_state_e state_q, state_d;
  logic [7:0] strb_q, strb_d;
  logic       write_q, write_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic [7:0] prdata_q, prdata_d;
  logic [7:0] wdata_q, wdata_d;

  logic [7:0] dec_strb;
  logic       dec_err;

  apb_spi_addr_dec #(
    .AddrW (ADDR_W)
  ) u_addr_dec (
    .addr  (i_PADDR),
    .write (i_PWRITE),
    .strb  (dec_strb),
    .err   (dec_err)
  );

  always_comb begin
    state_d   = state_q;
    strb_d    = '0;
    write_d   = write_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      StIdle: begin
        // Only a setup phase starts a transfer; a lone PENABLE is ignored.
        if (i_PSEL && !i_PENABLE) begin
          write_d = i_PWRITE;
          wdata_d = i_PWDATA;
          if (dec_err) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = StResp;
          end else begin
            strb_d  = dec_strb;
            state_d = StStrobe;
          end
        end
      end
      StStrobe: begin
        if (!i_PSEL) begin
          state_d = StIdle;
        end else if (write_q) begin
          pready_d = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = StRwait;
        end
      end
      StRwait: begin
        if (!i_PSEL) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            prdata_d = i_RDATA;
            pready_d = 1'b1;
            state_d  = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q   <= StIdle;
      strb_q    <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_PRDATA  = prdata_q;
  assign o_PREADY  = pready_q;
  assign o_PSLVERR = pslverr_q;
  assign o_WDATA   = wdata_q;
  assign o_WR0     = strb_q[STB_WR0];
  assign o_WR1     = strb_q[STB_WR1];
  assign o_WR2     = strb_q[STB_WR2];
  assign o_WR3     = strb_q[STB_WR3];
  assign o_DR0     = strb_q[STB_DR0];
  assign o_DR1     = strb_q[STB_DR1];
  assign o_DR2     = strb_q[STB_DR2];
  assign o_DR3     = strb_q[STB_DR3];

endmodule

// File: tb/tb_apb_spi_regif.sv
// Scoreboard bench for apb_spi_regif: the driver queues expected strobes and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_apb_spi_regif;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned RD_LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata, rdata, prdata, wdata;
  logic [3:0]        wr, dr;

  logic              rst3, psel3, penable3, pwrite3, pready3, pslverr3;
  logic [ADDR_W-1:0] paddr3;
  logic [7:0]        pwdata3, rdata3, prdata3, wdata3;
  logic [3:0]        wr3, dr3;
  bit                lat3_done;

  int checks   = 0;
  int failures = 0;

  typedef struct { int idx; logic [7:0] wdata; } strb_exp_t;
  typedef struct { logic err; logic [7:0] prdata; logic [7:0] wdata; int waits; } resp_exp_t;
  strb_exp_t strb_q[$];
  resp_exp_t resp_q[$];
  logic [7:0] m_prdata;
  int         mon_waits;

  apb_spi_regif #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dut (
    .i_PCLK(clk), .i_PRESET(rst), .i_PSEL(psel), .i_PENABLE(penable), .i_PWRITE(pwrite),
    .i_PADDR(paddr), .i_PWDATA(pwdata), .o_PRDATA(prdata), .o_PREADY(pready),
    .o_PSLVERR(pslverr), .o_WR0(wr[0]), .o_WR1(wr[1]), .o_WR2(wr[2]), .o_WR3(wr[3]),
    .o_DR0(dr[0]), .o_DR1(dr[1]), .o_DR2(dr[2]), .o_DR3(dr[3]), .o_WDATA(wdata),
    .i_RDATA(rdata)
  );

  apb_spi_regif #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT3)) u_dut3 (
    .i_PCLK(clk), .i_PRESET(rst3), .i_PSEL(psel3), .i_PENABLE(penable3), .i_PWRITE(pwrite3),
    .i_PADDR(paddr3), .i_PWDATA(pwdata3), .o_PRDATA(prdata3), .o_PREADY(pready3),
    .o_PSLVERR(pslverr3), .o_WR0(wr3[0]), .o_WR1(wr3[1]), .o_WR2(wr3[2]), .o_WR3(wr3[3]),
    .o_DR0(dr3[0]), .o_DR1(dr3[1]), .o_DR2(dr3[2]), .o_DR3(dr3[3]), .o_WDATA(wdata3),
    .i_RDATA(rdata3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Strobe vector {DR3..DR0, WR3..WR0}: a legal access lights the bit whose
  // position equals its register address; -1 marks an illegal access.
  function automatic int exp_idx(input logic w, input logic [ADDR_W-1:0] a);
    if (int'(a) > 7) return -1;
    if (w && int'(a) < 4) return int'(a);
    if (!w && int'(a) >= 4) return int'(a);
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [7:0] sv;
    int         pos;
    strb_exp_t  se;
    resp_exp_t  re;
    sv = {dr, wr};
    if (sv != 8'h00) begin
      chk("strobe_onehot", 32'($countones(sv)), 32'd1);
      if (strb_q.size() == 0) begin
        chk("unexpected_strobe", 32'(sv), 32'd0);
      end else begin
        se  = strb_q.pop_front();
        pos = 0;
        for (int i = 0; i < 8; i++) if (sv[i]) pos = i;
        chk("strobe_index", 32'(pos), 32'(se.idx));
        chk("strobe_wdata", 32'(wdata), 32'(se.wdata));
      end
    end
    if (psel && !penable) mon_waits = 0;
    else if (psel && penable && !pready) mon_waits++;
    if (pready) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_pready", 32'(pready), 32'd0);
      end else begin
        re = resp_q.pop_front();
        chk("resp_pslverr", 32'(pslverr), 32'(re.err));
        chk("resp_prdata", 32'(prdata), 32'(re.prdata));
        chk("resp_wdata", 32'(wdata), 32'(re.wdata));
        chk("resp_wait_states", 32'(mon_waits), 32'(re.waits));
      end
    end else if (pslverr) begin
      chk("pslverr_without_pready", 32'(pslverr), 32'd0);
    end
  end

  task automatic xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                      input logic [7:0] rv, input bit abort_req);
    int        idx;
    bit        abort;
    bit        got;
    strb_exp_t se;
    resp_exp_t re;
    idx   = exp_idx(w, a);
    abort = abort_req && !w && idx >= 0;
    if (idx >= 0) begin
      se.idx   = idx;
      se.wdata = d;
      strb_q.push_back(se);
    end
    if (!abort) begin
      re.err   = (idx < 0);
      re.wdata = d;
      if (idx < 0) re.waits = 0;
      else if (w) re.waits = 1;
      else begin
        re.waits = int'(RD_LAT) + 1;
        m_prdata = rv;
      end
      re.prdata = m_prdata;
      resp_q.push_back(re);
    end
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    rdata = rv ^ 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      // Read data is only valid in the cycle the capture edge closes.
      rdata = (k == int'(RD_LAT)) ? rv : rv ^ 8'($urandom_range(1, 255));
      if (abort && k == 1) begin
        psel = 1'b0; penable = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        return;
      end
      @(negedge clk);
      if (pready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("xfer_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag, input logic [7:0] pd, input logic pr,
                              input logic ps, input logic [7:0] sv, input logic [7:0] wd);
    chk({tag, "_prdata"}, 32'(pd), 32'd0);
    chk({tag, "_pready"}, 32'(pr), 32'd0);
    chk({tag, "_pslverr"}, 32'(ps), 32'd0);
    chk({tag, "_strobes"}, 32'(sv), 32'd0);
    chk({tag, "_wdata"}, 32'(wd), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required TB_RESULT before 200000");
    $fatal(1);
  end

  initial begin : lat3
    int k;
    int nstrb;
    bit got;
    rst3 = 1'b1; psel3 = 1'b0; penable3 = 1'b0; pwrite3 = 1'b0;
    paddr3 = '0; pwdata3 = '0; rdata3 = '0; lat3_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst3 = 1'b0;
    @(posedge clk); #1;
    psel3 = 1'b1; pwrite3 = 1'b0; paddr3 = 4'h5; pwdata3 = 8'h11;
    @(posedge clk); #1;
    penable3 = 1'b1;
    got = 1'b0; nstrb = 0; k = 0;
    while (k < 40 && !got) begin
      rdata3 = (k == int'(RD_LAT3)) ? 8'h7E : 8'h81;
      @(negedge clk);
      if (k == 0) chk("lat3_dr1_strobe", 32'({dr3, wr3}), 32'h20);
      nstrb += $countones({dr3, wr3});
      if (pready3) got = 1'b1;
      else begin
        k++;
        @(posedge clk); #1;
      end
    end
    chk("lat3_wait_states", 32'(k), 32'd4);
    chk("lat3_prdata", 32'(prdata3), 32'h7E);
    chk("lat3_pslverr", 32'(pslverr3), 32'd0);
    chk("lat3_strobe_count", 32'(nstrb), 32'd1);
    @(posedge clk); #1;
    psel3 = 1'b0; penable3 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("lat3_idle_pready", 32'(pready3), 32'd0);
    lat3_done = 1'b1;
  end

  initial begin : main
    strb_exp_t se;
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d, rv;
    bit                ab;
    int                gap;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rdata = '0; m_prdata = '0; mon_waits = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset", prdata, pready, pslverr, {dr, wr}, wdata);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(1'b1, 4'h0, 8'h25, 8'h00, 1'b0);  // write CONFIG
    xfer(1'b0, 4'h4, 8'h00, 8'h02, 1'b0);  // read STATE
    xfer(1'b1, 4'h5, 8'h33, 8'h00, 1'b0);  // illegal: write to read-only
    xfer(1'b0, 4'h1, 8'h44, 8'h55, 1'b0);  // illegal: read from write-only
    xfer(1'b0, 4'h8, 8'h66, 8'h77, 1'b0);  // illegal: upper address bit
    xfer(1'b1, 4'hC, 8'h88, 8'h00, 1'b0);
    xfer(1'b1, 4'h1, 8'hA5, 8'h00, 1'b0);  // back-to-back writes
    xfer(1'b1, 4'h3, 8'h02, 8'h00, 1'b0);
    xfer(1'b0, 4'h6, 8'h00, 8'hE1, 1'b1);  // abort during RWAIT
    xfer(1'b0, 4'h6, 8'h00, 8'h3C, 1'b0);

    // PENABLE without a setup phase must not start a transfer.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      w   = 1'($urandom_range(0, 1));
      a   = ADDR_W'($urandom_range(0, 9));
      d   = 8'($urandom);
      rv  = 8'($urandom);
      ab  = ($urandom_range(0, 9) == 0);
      xfer(w, a, d, rv, ab);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    // Reset while the write strobe is up: the strobe already issued stays,
    // nothing follows and every output clears on the reset edge.
    xfer(1'b0, 4'h5, 8'h00, 8'h9C, 1'b0);
    se.idx = 0; se.wdata = 8'hC3;
    strb_q.push_back(se);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 8'hC3;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    m_prdata = '0;
    chk_all_zero("reset_mid", prdata, pready, pslverr, {dr, wr}, wdata);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    xfer(1'b1, 4'h2, 8'h5A, 8'h00, 1'b0);
    xfer(1'b0, 4'h7, 8'h00, 8'hB4, 1'b0);

    repeat (4) begin @(posedge clk); #1; end
    chk("strobes_left", 32'(strb_q.size()), 32'd0);
    chk("responses_left", 32'(resp_q.size()), 32'd0);
    for (int i = 0; i < 200 && !lat3_done; i++) @(posedge clk);
    chk("lat3_finished", 32'(lat3_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
